// File: rtl/interrupt_controller_pkg.sv
// ---------------------------------------------------------------------------
// interrupt_controller_pkg
// Shared definitions for the external interrupt controller: register word
// indices within the 8-word window, the source-ID type and the "no source" ID.
// ---------------------------------------------------------------------------
package interrupt_controller_pkg;

   localparam logic [2:0] IRQ_PENDING    = 3'd0;
   localparam logic [2:0] IRQ_ENABLE     = 3'd1;
   localparam logic [2:0] IRQ_EDGE_MODE  = 3'd2;
   localparam logic [2:0] IRQ_CLAIM      = 3'd3;
   localparam logic [2:0] IRQ_IN_SERVICE = 3'd4;

   // Source IDs are 1-based; ID 0 means no source.
   typedef logic [4:0] irq_id_t;

   localparam irq_id_t IRQ_ID_NONE = 5'd0;

endpackage

// File: rtl/interrupt_controller_gateway.sv
// ---------------------------------------------------------------------------
// irq_gateway
// Per-source front end: two-flop synchroniser, a third delay flop for
// rising-edge detection, and the pending flop.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   src           raw (asynchronous) device line
//   edge_mode     1 = edge triggered, 0 = level triggered
//   in_service    source currently claimed by firmware
//   claim_clear   this source is being claimed on this edge
//   pending       latched pending state
// ---------------------------------------------------------------------------
module irq_gateway (
   input  logic clk,
   input  logic rst,
   input  logic src,
   input  logic edge_mode,
   input  logic in_service,
   input  logic claim_clear,
   output logic pending
);

   logic sync1_reg;
   logic sync2_reg;
   logic delay_reg;
   logic pending_reg;
   logic rise;

   assign rise    = sync2_reg & ~delay_reg;
   assign pending = pending_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg   <= 1'b0;
         sync2_reg   <= 1'b0;
         delay_reg   <= 1'b0;
         pending_reg <= 1'b0;
      end else begin
         sync1_reg <= src;
         sync2_reg <= sync1_reg;
         delay_reg <= sync2_reg;
         // A claim always wins: an edge arriving on the claim cycle is dropped.
         if (claim_clear) begin
            pending_reg <= 1'b0;
         end else if (edge_mode) begin
            // Edges are captured even while in service so they are not lost.
            if (rise) begin
               pending_reg <= 1'b1;
            end
         end else if (sync2_reg && !in_service) begin
            pending_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
// Memory-mapped external interrupt controller. Latches up to NUM_SOURCES
// device lines, masks them with ENABLE, raises a single registered request
// and lets firmware claim/complete sources through a register window.
// Ports:
//   clk_i, reset_i    clock, asynchronous active-high reset
//   src_i             raw device lines, bit n is source ID n+1
//   addr_i            register word index
//   read_enable_i     read strobe; read_data_o valid one cycle later
//   read_data_o       registered read data (0 when not reading)
//   write_enable_i    write strobe
//   write_data_i      write data
//   irq_o             registered request to the CPU
// ---------------------------------------------------------------------------
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int NUM_SOURCES = 8
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [NUM_SOURCES-1:0] src_i,
   input  logic [2:0]             addr_i,
   input  logic                   read_enable_i,
   output logic [31:0]            read_data_o,
   input  logic                   write_enable_i,
   input  logic [31:0]            write_data_i,
   output logic                   irq_o
);

   logic [NUM_SOURCES-1:0] pending;
   logic [NUM_SOURCES-1:0] enable_reg;
   logic [NUM_SOURCES-1:0] edge_mode_reg;
   logic [NUM_SOURCES-1:0] in_service_reg;
   logic [NUM_SOURCES-1:0] claimable;
   logic [NUM_SOURCES-1:0] claim_mask;
   logic [NUM_SOURCES-1:0] complete_mask;
   logic [31:0]            read_data_reg;
   logic                   irq_reg;
   irq_id_t                claim_id;
   logic                   claim_fire;
   logic                   complete_we;
   logic                   unused_write_data;

   assign unused_write_data = ^write_data_i;

   assign claimable   = pending & enable_reg & ~in_service_reg;
   assign claim_fire  = read_enable_i && (addr_i == IRQ_CLAIM) && (claim_id != IRQ_ID_NONE);
   assign complete_we = write_enable_i && (addr_i == IRQ_CLAIM);

   // Lowest index wins: scan downwards so the last hit is the lowest.
   always_comb begin
      claim_id = IRQ_ID_NONE;
      for (int n = NUM_SOURCES - 1; n >= 0; n--) begin
         if (claimable[n]) begin
            claim_id = irq_id_t'(n + 1);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
         // ID 0 and out-of-range IDs never match any gi, so they fall out here.
         assign claim_mask[gi]    = claim_fire && (claim_id == irq_id_t'(gi + 1));
         assign complete_mask[gi] = complete_we && in_service_reg[gi] &&
                                    (write_data_i[4:0] == irq_id_t'(gi + 1));

         irq_gateway u_gateway (
            .clk         (clk_i),
            .rst         (reset_i),
            .src         (src_i[gi]),
            .edge_mode   (edge_mode_reg[gi]),
            .in_service  (in_service_reg[gi]),
            .claim_clear (claim_mask[gi]),
            .pending     (pending[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         enable_reg     <= '0;
         edge_mode_reg  <= '0;
         in_service_reg <= '0;
         read_data_reg  <= '0;
         irq_reg        <= 1'b0;
      end else begin
         irq_reg <= |claimable;

         if (write_enable_i && (addr_i == IRQ_ENABLE)) begin
            enable_reg <= write_data_i[NUM_SOURCES-1:0];
         end
         if (write_enable_i && (addr_i == IRQ_EDGE_MODE)) begin
            edge_mode_reg <= write_data_i[NUM_SOURCES-1:0];
         end

         // Complete is applied before claim so a same-cycle complete+claim
         // of one ID leaves it in service.
         in_service_reg <= (in_service_reg & ~complete_mask) | claim_mask;

         if (read_enable_i) begin
            case (addr_i)
               IRQ_PENDING:    read_data_reg <= 32'(pending);
               IRQ_ENABLE:     read_data_reg <= 32'(enable_reg);
               IRQ_EDGE_MODE:  read_data_reg <= 32'(edge_mode_reg);
               IRQ_CLAIM:      read_data_reg <= 32'(claim_id);
               IRQ_IN_SERVICE: read_data_reg <= 32'(in_service_reg);
               default:        read_data_reg <= '0;
            endcase
         end else begin
            read_data_reg <= '0;
         end
      end
   end

   assign read_data_o = read_data_reg;
   assign irq_o       = irq_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

   localparam int N = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  src = '0;
   logic [2:0]    addr = '0;
   logic          re = 1'b0;
   logic [31:0]   rd;
   logic          we = 1'b0;
   logic [31:0]   wd = '0;
   logic          irq;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [N-1:0]  m_pend, m_en, m_mode, m_isv;
   logic [N-1:0]  h1, h2, h3;
   logic [31:0]   m_rd;
   logic          m_irq;

   always #5 clk = ~clk;

   interrupt_controller #(.NUM_SOURCES(N)) dut (
      .clk_i          (clk),
      .reset_i        (rst),
      .src_i          (src),
      .addr_i         (addr),
      .read_enable_i  (re),
      .read_data_o    (rd),
      .write_enable_i (we),
      .write_data_i   (wd),
      .irq_o          (irq)
   );

   task automatic do_reset();
      rst = 1'b1; src = '0; re = 1'b0; we = 1'b0; addr = '0; wd = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      re = 1'b1; addr = a;
      @(posedge clk);
      #1 d = rd;
      @(negedge clk);
      re = 1'b0;
      $display("read  addr=%0d data=%08h irq=%0b", a, d, irq);
   endtask

   task automatic do_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; addr = a; wd = d;
      @(negedge clk);
      we = 1'b0;
      $display("write addr=%0d data=%08h irq=%0b", a, d, irq);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [N-1:0] m);
      @(negedge clk);
      src = src | m;
      @(negedge clk);
      src = src & ~m;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      total++;
      if (rd !== 32'h0 || irq !== 1'b0) begin
         bad++; $display("FAIL reset_outputs got rd=%h irq=%b want rd=0 irq=0", rd, irq);
      end
      for (int a = 0; a < 8; a++) begin
         do_read(3'(a), d);
         total++;
         if (d !== 32'h0) begin
            bad++; $display("FAIL reset_reg%0d got=%h want=0", a, d);
         end
      end
   endtask

   task automatic test_level();
      logic [31:0] d;
      do_reset();
      do_write(3'd1, 32'h04);
      @(negedge clk);
      src[2] = 1'b1;
      tick(3);
      total++;
      if (irq !== 1'b0) begin
         bad++; $display("FAIL lvl_irq_early got=%b want=0", irq);
      end
      do_read(3'd0, d);
      total++;
      if (d !== 32'h04 || irq !== 1'b1) begin
         bad++; $display("FAIL lvl_pending got pend=%h irq=%b want pend=04 irq=1", d, irq);
      end
      do_read(3'd3, d);
      total++;
      if (d !== 32'd3) begin
         bad++; $display("FAIL lvl_claim got=%0d want=3", d);
      end
      do_read(3'd4, d);
      total++;
      if (d !== 32'h04 || irq !== 1'b0) begin
         bad++; $display("FAIL lvl_in_service got isv=%h irq=%b want isv=04 irq=0", d, irq);
      end
      do_read(3'd0, d);
      total++;
      if (d !== 32'h0) begin
         bad++; $display("FAIL lvl_no_repend got=%h want=0", d);
      end
      do_write(3'd3, 32'd3);
      tick(2);
      total++;
      if (irq !== 1'b1) begin
         bad++; $display("FAIL lvl_reassert got=%b want=1", irq);
      end
   endtask

   task automatic test_edge_priority();
      logic [31:0] d;
      do_reset();
      do_write(3'd2, 32'h21);
      do_write(3'd1, 32'h21);
      pulse(8'h21);
      tick(4);
      do_read(3'd3, d);
      total++;
      if (d !== 32'd1) begin
         bad++; $display("FAIL prio_first got=%0d want=1", d);
      end
      do_read(3'd3, d);
      total++;
      if (d !== 32'd6) begin
         bad++; $display("FAIL prio_second got=%0d want=6", d);
      end
      do_read(3'd3, d);
      total++;
      if (d !== 32'd0 || irq !== 1'b0) begin
         bad++; $display("FAIL prio_third got id=%0d irq=%b want id=0 irq=0", d, irq);
      end
      do_read(3'd4, d);
      total++;
      if (d !== 32'h21) begin
         bad++; $display("FAIL prio_isv got=%h want=21", d);
      end
   endtask

   task automatic test_edge_in_service();
      logic [31:0] d;
      do_reset();
      do_write(3'd2, 32'h02);
      do_write(3'd1, 32'h02);
      pulse(8'h02);
      tick(4);
      do_read(3'd3, d);
      total++;
      if (d !== 32'd2) begin
         bad++; $display("FAIL isv_claim got=%0d want=2", d);
      end
      pulse(8'h02);
      tick(4);
      do_read(3'd0, d);
      total++;
      if (d !== 32'h02 || irq !== 1'b0) begin
         bad++; $display("FAIL isv_repend got pend=%h irq=%b want pend=02 irq=0", d, irq);
      end
      do_write(3'd3, 32'd2);
      tick(1);
      total++;
      if (irq !== 1'b1) begin
         bad++; $display("FAIL isv_irq_after_complete got=%b want=1", irq);
      end
      do_read(3'd3, d);
      total++;
      if (d !== 32'd2) begin
         bad++; $display("FAIL isv_reclaim got=%0d want=2", d);
      end
   endtask

   task automatic test_enable();
      logic [31:0] d;
      do_reset();
      @(negedge clk);
      src[4] = 1'b1;
      tick(5);
      total++;
      if (irq !== 1'b0) begin
         bad++; $display("FAIL en_masked_irq got=%b want=0", irq);
      end
      do_read(3'd3, d);
      total++;
      if (d !== 32'd0) begin
         bad++; $display("FAIL en_masked_claim got=%0d want=0", d);
      end
      do_read(3'd0, d);
      total++;
      if (d !== 32'h10) begin
         bad++; $display("FAIL en_pending got=%h want=10", d);
      end
      do_write(3'd1, 32'h10);
      total++;
      if (irq !== 1'b0) begin
         bad++; $display("FAIL en_lag got=%b want=0", irq);
      end
      tick(1);
      total++;
      if (irq !== 1'b1) begin
         bad++; $display("FAIL en_raise got=%b want=1", irq);
      end
   endtask

   task automatic test_ignored_writes();
      logic [31:0] d;
      do_reset();
      do_write(3'd2, 32'h03);
      do_write(3'd1, 32'h03);
      pulse(8'h03);
      tick(4);
      do_read(3'd3, d);
      total++;
      if (d !== 32'd1) begin
         bad++; $display("FAIL ign_claim got=%0d want=1", d);
      end
      do_write(3'd3, 32'd0);
      do_write(3'd3, 32'd9);
      do_write(3'd3, 32'd2);
      do_read(3'd4, d);
      total++;
      if (d !== 32'h01) begin
         bad++; $display("FAIL ign_complete got isv=%h want=01", d);
      end
      do_write(3'd0, 32'hFFFF_FFFF);
      do_write(3'd6, 32'hFFFF_FFFF);
      do_read(3'd0, d);
      total++;
      if (d !== 32'h02) begin
         bad++; $display("FAIL ign_pending got=%h want=02", d);
      end
      do_read(3'd1, d);
      total++;
      if (d !== 32'h03) begin
         bad++; $display("FAIL ign_enable got=%h want=03", d);
      end
      for (int a = 5; a < 8; a++) begin
         do_read(3'(a), d);
         total++;
         if (d !== 32'h0) begin
            bad++; $display("FAIL ign_unused%0d got=%h want=0", a, d);
         end
      end
      do_read(3'd2, d);
      tick(1);
      total++;
      if (rd !== 32'h0) begin
         bad++; $display("FAIL ign_rd_idle got=%h want=0", rd);
      end
   endtask

   task automatic test_reset_mid_claim();
      logic [31:0] d;
      do_reset();
      do_write(3'd1, 32'h0C);
      @(negedge clk);
      src = 8'h0C;
      tick(5);
      do_read(3'd3, d);
      total++;
      if (d !== 32'd3 || rd !== 32'd3 || irq !== 1'b1) begin
         bad++; $display("FAIL rst_pre_claim got id=%0d rd=%h irq=%b want 3/3/1", d, rd, irq);
      end
      #1 rst = 1'b1;
      src = '0;
      #1;
      total++;
      if (rd !== 32'h0 || irq !== 1'b0) begin
         bad++; $display("FAIL rst_async got rd=%h irq=%b want 0/0", rd, irq);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 5; a++) begin
         do_read(3'(a), d);
         total++;
         if (d !== 32'h0 || irq !== 1'b0) begin
            bad++; $display("FAIL rst_after_reg%0d got=%h irq=%b want 0/0", a, d, irq);
         end
      end
   endtask

   // Reference model: applies the controller's rules once per clock edge.
   task automatic model_step();
      logic [N-1:0] claimable, rise, npend, nisv;
      int cid;
      int id;
      claimable = m_pend & m_en & ~m_isv;
      cid = 0;
      for (int n = N - 1; n >= 0; n--) if (claimable[n]) cid = n + 1;
      m_rd = 32'h0;
      if (re) begin
         case (addr)
            3'd0: m_rd = 32'(m_pend);
            3'd1: m_rd = 32'(m_en);
            3'd2: m_rd = 32'(m_mode);
            3'd3: m_rd = 32'(cid);
            3'd4: m_rd = 32'(m_isv);
            default: m_rd = 32'h0;
         endcase
      end
      m_irq = (claimable != '0);
      rise = h2 & ~h3;
      npend = m_pend;
      nisv  = m_isv;
      for (int n = 0; n < N; n++) begin
         if (m_mode[n] ? rise[n] : (h2[n] && !m_isv[n])) npend[n] = 1'b1;
      end
      if (we && addr == 3'd3) begin
         id = int'(wd[4:0]);
         if (id >= 1 && id <= N && m_isv[id-1]) nisv[id-1] = 1'b0;
      end
      if (re && addr == 3'd3 && cid != 0) begin
         npend[cid-1] = 1'b0;
         nisv[cid-1]  = 1'b1;
      end
      if (we && addr == 3'd1) m_en = wd[N-1:0];
      if (we && addr == 3'd2) m_mode = wd[N-1:0];
      m_pend = npend;
      m_isv  = nisv;
      h3 = h2; h2 = h1; h1 = src;
   endtask

   task automatic test_random();
      logic [N-1:0] flip;
      do_reset();
      m_pend = '0; m_en = '0; m_mode = '0; m_isv = '0;
      h1 = '0; h2 = '0; h3 = '0; m_rd = '0; m_irq = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         flip = '0;
         for (int n = 0; n < N; n++) flip[n] = ($urandom_range(0, 5) == 0);
         src  = src ^ flip;
         addr = ($urandom_range(0, 9) < 4) ? 3'd3 : 3'($urandom_range(0, 7));
         re   = ($urandom_range(0, 1) == 1);
         we   = ($urandom_range(0, 2) == 0);
         wd   = (addr == 3'd3) ? 32'($urandom_range(0, 10)) : $urandom;
         model_step();
         @(posedge clk);
         #1;
         total++;
         if (rd !== m_rd || irq !== m_irq) begin
            bad++;
            $display("FAIL rand_cycle%0d got rd=%h irq=%b want rd=%h irq=%b", c, rd, irq, m_rd, m_irq);
         end
         $display("cycle %0d src=%02h addr=%0d re=%0b we=%0b wd=%08h rd=%08h irq=%0b",
                  c, src, addr, re, we, wd, rd, irq);
      end
      @(negedge clk);
      re = 1'b0; we = 1'b0;
   endtask

   initial begin
      test_reset();
      test_level();
      test_edge_priority();
      test_edge_in_service();
      test_enable();
      test_ignored_writes();
      test_reset_mid_claim();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Memory-mapped external interrupt controller feeding the `interrupt_i` input of the CPU CSR block.
- Synchronises up to NUM_SOURCES device interrupt lines and latches each as level- or edge-triggered.
- Masks the latched lines with an enable register.
- Drives a single registered request line; firmware then claims and completes individual sources through a register window.

Parameters:
- NUM_SOURCES, 8, number of device interrupt lines (1..31); source IDs are 1..NUM_SOURCES, ID 0 means "none".

Ports:
- clk_i  input  1  clock
- reset_i  input  1  asynchronous, active-high reset
- src_i  input  NUM_SOURCES  raw device interrupt lines (asynchronous to clk_i); bit n is source ID n+1
- addr_i  input  3  register word index (byte address [4:2] within the window)
- read_enable_i  input  1  register read strobe
- read_data_o  output  32  registered read data
- write_enable_i  input  1  register write strobe
- write_data_i  input  32  write data
- irq_o  output  1  registered interrupt request, to CSR `interrupt_i`

Behaviour:
- Reset (asynchronous, active-high): synchronisers, pending, enable, edge_mode, in_service, read_data_o and irq_o all clear to 0.
- Synchroniser:
  - Two-flop synchroniser per source.
  - Edge detect compares the synchronised value with a third delay flop.
  - Result: input-to-pending latency of 3 cycles.
- Pending set rules:
  - Edge mode (edge_mode[n]=1): a 0->1 transition sets pending[n]; this also applies while the source is in service.
  - Level mode: pending[n] is set when the synchronised level is 1 and in_service[n]=0.
- Claimable vector = pending & enable & ~in_service.
- irq_o = registered OR of the claimable vector (1-cycle lag).
- Register map (word index):
  - 0 PENDING: read-only; writes ignored.
  - 1 ENABLE: read/write, bits [NUM_SOURCES-1:0].
  - 2 EDGE_MODE: read/write; 1 = edge, 0 = level.
  - 3 CLAIM:
    - Read returns the lowest-index claimable source ID (1-based), or 0 if none.
    - The same clock edge clears that pending bit and sets its in_service bit.
    - Write = complete: write_data_i[4:0] is an ID whose in_service bit is cleared.
    - Completing ID 0, an out-of-range ID, or an ID not in service is ignored.
  - 4 IN_SERVICE: read-only.
  - 5..7: read 0, writes ignored.
- Read latency: 1 cycle, registered. read_data_o is 0 on any cycle after read_enable_i=0; unused upper bits are 0.
- Simultaneous events:
  - Claim and new edge on the same source in the same cycle: the claim wins and pending is left clear. That edge is lost; edges arriving on later cycles while in service re-set pending.
  - Complete and claim in the same cycle: the claim is computed from pre-write state, then both updates apply. Completing ID k and claiming ID k together leaves in_service[k]=1.
  - Level source still high at complete: pending re-sets on the next cycle; irq_o re-asserts one cycle later.
  - ENABLE write clearing a bit does not clear pending; re-enabling re-raises irq_o.
  - Disabling a source does not clear its in_service bit.
  - EDGE_MODE change does not clear pending.
- Reset asserted mid-claim: all state clears and the claim is lost; in_service must be 0 after reset.

Decomposition:
- Package common gains:
  - IRQ_PENDING/IRQ_ENABLE/IRQ_EDGE_MODE/IRQ_CLAIM/IRQ_IN_SERVICE word-index localparams
  - irq_id_t (5-bit)
  - IRQ_ID_NONE = 0
- Sub-module irq_gateway, one instance per source:
  - Contains the synchroniser, edge detect and pending flop.
  - Inputs: edge_mode, in_service, claim_clear.
  - Output: pending.
- Top level handles:
  - the priority encoder (lowest index wins)
  - enable / edge_mode / in_service registers
  - register decode, the registered read mux and irq_o

Test Plan:
- Level source 2 (ID 3), EDGE_MODE=0, ENABLE=0x04; raise src_i[2] -> PENDING=0x04 after 3 cycles, irq_o=1 one cycle later. CLAIM read returns 3, IN_SERVICE=0x04, irq_o drops. Complete 3 with src_i[2] still high -> pending re-sets, irq_o=1 again.
- Edge sources 0 and 5, ENABLE=0x21, pulse both in the same cycle -> first CLAIM returns 1, second returns 6, third returns 0, irq_o=0 after the second claim.
- Edge source 1 claimed (ID 2); pulse src_i[1] again while in service -> PENDING bit 1 set, irq_o stays 0 until complete(2), then irq_o=1 and CLAIM returns 2.
- ENABLE=0 with source 4 pending -> irq_o=0, CLAIM returns 0. Set ENABLE bit 4 -> irq_o=1 one cycle later.
- Complete(0), complete(9), complete of an ID not in service -> IN_SERVICE unchanged. Write to PENDING or index 6 -> no state change; reads of indices 5..7 return 0.
- Assert reset_i asynchronously with sources pending and in service (mid-claim) -> read_data_o, irq_o, PENDING, ENABLE, IN_SERVICE all 0 immediately and after deassertion.
